// File: rtl/game_ctrl_if.sv
// Control/status bundle between the game controller and its draw stages.
// The controller sits on the slave side; the stimulus or compositor drives the master side.
interface game_ctrl_if;
    logic        btn_start;
    logic        collide;
    logic [1:0]  gamestate;
    logic        scroll_tick;
    logic [15:0] score;
    logic [15:0] hi_score;
    logic [3:0]  speed_lvl;

    modport master (
        output btn_start, collide,
        input  gamestate, scroll_tick, score, hi_score, speed_lvl
    );

    modport slave (
        input  btn_start, collide,
        output gamestate, scroll_tick, score, hi_score, speed_lvl
    );
endinterface

// File: rtl/game_ctrl.sv
// Game state machine, scroll-step generator with score-driven speed-up,
// and BCD score/high-score keeping for the draw pipeline.
module game_ctrl #(
    parameter int unsigned TICK_INIT   = 500000,
    parameter int unsigned TICK_MIN    = 100000,
    parameter int unsigned TICK_STEP   = 20000,
    parameter int unsigned SCORE_DIV   = 6,
    parameter int unsigned SPEEDUP_PTS = 100,
    parameter int unsigned DEAD_HOLD   = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_UNBEGIN = 2'b00,
        ST_RUNNING = 2'b01,
        ST_DEAD    = 2'b10
    } state_t;

    localparam logic [25:0] P_TICK_INIT  = 26'(TICK_INIT);
    localparam logic [25:0] P_TICK_MIN   = 26'(TICK_MIN);
    localparam logic [25:0] P_TICK_STEP  = 26'(TICK_STEP);
    localparam logic [25:0] P_DEC_FLOOR  = 26'(TICK_MIN + TICK_STEP);
    localparam logic [3:0]  P_STEP_LAST  = 4'(SCORE_DIV - 1);
    localparam logic [7:0]  P_PTS_LAST   = 8'(SPEEDUP_PTS - 1);
    localparam logic [25:0] P_HOLD_LAST  = 26'(DEAD_HOLD - 1);

    state_t      r_state;
    logic        r_tick;
    logic [15:0] r_score;
    logic [15:0] r_hi_score;
    logic [3:0]  r_speed_lvl;
    logic [25:0] r_div;
    logic [25:0] r_period;
    logic [25:0] r_hold;
    logic [3:0]  r_step;
    logic [7:0]  r_pts;
    logic        r_btn_prev;
    logic        r_armed;

    logic        w_start_evt;
    logic        w_wrap;
    logic        w_score_inc;
    logic        w_speedup;
    logic [25:0] w_period_dec;

    // BCD increment with per-digit carry; 9999 is sticky.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry && (v[d*4 +: 4] == 4'd9)) begin
                    res[d*4 +: 4] = 4'd0;
                end else if (carry) begin
                    res[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end else begin
                    res[d*4 +: 4] = v[d*4 +: 4];
                end
            end
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Digit-wise BCD greater-than, deciding on the most significant differing digit.
    function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int d = 3; d >= 0; d--) begin
            if (!decided && (a[d*4 +: 4] != b[d*4 +: 4])) begin
                gt      = (a[d*4 +: 4] > b[d*4 +: 4]);
                decided = 1'b1;
            end else begin
                decided = decided;
            end
        end
        return gt;
    endfunction

    // r_armed stays low until the button has been seen released after reset,
    // so a button held through reset release cannot start a game.
    assign w_start_evt  = bus.btn_start & ~r_btn_prev & r_armed;
    assign w_wrap       = (r_state == ST_RUNNING) && !bus.collide && (r_div == (r_period - 26'd1));
    assign w_score_inc  = w_wrap && (r_step == P_STEP_LAST) && (r_score != 16'h9999);
    assign w_speedup    = w_score_inc && (r_pts == P_PTS_LAST);
    assign w_period_dec = (r_period >= P_DEC_FLOOR) ? (r_period - P_TICK_STEP) : P_TICK_MIN;

    // Game FSM, scroll divider, score/speed bookkeeping and button edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_UNBEGIN;
            r_tick      <= 1'b0;
            r_score     <= 16'h0000;
            r_hi_score  <= 16'h0000;
            r_speed_lvl <= 4'd0;
            r_div       <= 26'd0;
            r_period    <= P_TICK_INIT;
            r_hold      <= 26'd0;
            r_step      <= 4'd0;
            r_pts       <= 8'd0;
            r_btn_prev  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_btn_prev <= bus.btn_start;
            r_armed    <= r_armed | ~bus.btn_start;
            r_tick     <= 1'b0;
            case (r_state)
                ST_UNBEGIN: begin
                    if (w_start_evt) begin
                        r_state <= ST_RUNNING;
                    end else begin
                        r_state <= ST_UNBEGIN;
                    end
                end
                ST_RUNNING: begin
                    if (bus.collide) begin
                        r_state <= ST_DEAD;
                        r_hold  <= 26'd0;
                        if (bcd_gt(r_score, r_hi_score)) begin
                            r_hi_score <= r_score;
                        end else begin
                            r_hi_score <= r_hi_score;
                        end
                    end else begin
                        r_tick  <= w_wrap;
                        r_div   <= w_wrap ? 26'd0 : (r_div + 26'd1);
                        r_score <= w_score_inc ? bcd_inc(r_score) : r_score;
                        if (w_wrap) begin
                            r_step <= (r_step == P_STEP_LAST) ? 4'd0 : (r_step + 4'd1);
                        end else begin
                            r_step <= r_step;
                        end
                        if (w_speedup) begin
                            r_pts       <= 8'd0;
                            r_period    <= w_period_dec;
                            r_speed_lvl <= (r_speed_lvl == 4'd15) ? 4'd15 : (r_speed_lvl + 4'd1);
                        end else if (w_score_inc) begin
                            r_pts <= r_pts + 8'd1;
                        end else begin
                            r_pts <= r_pts;
                        end
                    end
                end
                ST_DEAD: begin
                    if (w_start_evt && (r_hold == P_HOLD_LAST)) begin
                        r_state     <= ST_RUNNING;
                        r_score     <= 16'h0000;
                        r_div       <= 26'd0;
                        r_step      <= 4'd0;
                        r_pts       <= 8'd0;
                        r_period    <= P_TICK_INIT;
                        r_speed_lvl <= 4'd0;
                        r_hold      <= 26'd0;
                    end else if (r_hold != P_HOLD_LAST) begin
                        r_hold <= r_hold + 26'd1;
                    end else begin
                        r_hold <= r_hold;
                    end
                end
                default: begin
                    r_state <= ST_UNBEGIN;
                end
            endcase
        end
    end

    assign bus.gamestate   = r_state;
    assign bus.scroll_tick = r_tick;
    assign bus.score       = r_score;
    assign bus.hi_score    = r_hi_score;
    assign bus.speed_lvl   = r_speed_lvl;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with small timing parameters and hand-computed expectations.
module tb_game_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_iv;

    game_ctrl_if u_if ();

    game_ctrl #(
        .TICK_INIT  (10),
        .TICK_MIN   (4),
        .TICK_STEP  (3),
        .SCORE_DIV  (2),
        .SPEEDUP_PTS(3),
        .DEAD_HOLD  (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until scroll_tick is seen high; -1 if the budget runs out.
    task automatic wait_tick(input int limit, output int n);
        n = -1;
        for (int i = 1; (i <= limit) && (n < 0); i++) begin
            @(negedge clk);
            if (u_if.scroll_tick) begin
                n = i;
            end
        end
    endtask

    function automatic int exp_period(input int k);
        if (k <= 6) return 10;
        else if (k <= 12) return 7;
        else return 4;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        u_if.btn_start = 1'b1;
        u_if.collide   = 1'b0;

        #12;
        check_eq("rst_state", 32'(u_if.gamestate), 32'd0);
        check_eq("rst_tick",  32'(u_if.scroll_tick), 32'd0);
        check_eq("rst_score", 32'(u_if.score), 32'h0);
        check_eq("rst_hi",    32'(u_if.hi_score), 32'h0);
        check_eq("rst_speed", 32'(u_if.speed_lvl), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("held_btn_no_start", 32'(u_if.gamestate), 32'd0);

        u_if.btn_start = 1'b0;
        repeat (2) @(negedge clk);
        u_if.btn_start = 1'b1;
        check_eq("pre_edge_unbegin", 32'(u_if.gamestate), 32'd0);
        @(negedge clk);
        check_eq("start_running", 32'(u_if.gamestate), 32'd1);
        u_if.btn_start = 1'b0;

        for (int k = 1; k <= 19; k++) begin
            wait_tick(20, n_iv);
            check_eq($sformatf("tick%0d_interval", k), 32'(n_iv), 32'(exp_period(k)));
            if (k == 12) begin
                check_eq("score_12", 32'(u_if.score), 32'h0006);
                check_eq("speed_12", 32'(u_if.speed_lvl), 32'd2);
            end
            if (k == 18) begin
                check_eq("score_18", 32'(u_if.score), 32'h0009);
                check_eq("speed_18", 32'(u_if.speed_lvl), 32'd3);
            end
        end

        // Preload near saturation; held across one non-wrap edge before release.
        force dut.r_score = 16'h9998;
        @(negedge clk);
        release dut.r_score;
        wait_tick(20, n_iv);
        check_eq("sat_tick20_iv", 32'(n_iv), 32'd3);
        check_eq("sat_score_20", 32'(u_if.score), 32'h9999);
        for (int k = 21; k <= 23; k++) begin
            wait_tick(20, n_iv);
        end
        check_eq("sat_tick23_iv", 32'(n_iv), 32'd4);
        check_eq("sat_score_23", 32'(u_if.score), 32'h9999);
        check_eq("sat_speed_23", 32'(u_if.speed_lvl), 32'd3);

        // Collide on the exact divider-wrap edge.
        repeat (3) @(negedge clk);
        u_if.collide = 1'b1;
        @(negedge clk);
        u_if.collide = 1'b0;
        check_eq("collide_no_tick", 32'(u_if.scroll_tick), 32'd0);
        check_eq("collide_dead", 32'(u_if.gamestate), 32'd2);
        check_eq("collide_score", 32'(u_if.score), 32'h9999);
        check_eq("hi_update", 32'(u_if.hi_score), 32'h9999);

        repeat (2) @(negedge clk);
        u_if.btn_start = 1'b1;
        @(negedge clk);
        u_if.btn_start = 1'b0;
        check_eq("early_start_ignored", 32'(u_if.gamestate), 32'd2);
        repeat (3) @(negedge clk);
        u_if.btn_start = 1'b1;
        @(negedge clk);
        u_if.btn_start = 1'b0;
        check_eq("restart_state", 32'(u_if.gamestate), 32'd1);
        check_eq("restart_score", 32'(u_if.score), 32'h0);
        check_eq("restart_speed", 32'(u_if.speed_lvl), 32'd0);
        check_eq("restart_hi", 32'(u_if.hi_score), 32'h9999);
        wait_tick(20, n_iv);
        check_eq("restart_tick1_iv", 32'(n_iv), 32'd10);
        wait_tick(20, n_iv);
        check_eq("game2_score", 32'(u_if.score), 32'h0001);

        u_if.collide = 1'b1;
        @(negedge clk);
        u_if.collide = 1'b0;
        check_eq("game2_dead", 32'(u_if.gamestate), 32'd2);
        check_eq("game2_hi_kept", 32'(u_if.hi_score), 32'h9999);

        repeat (5) @(negedge clk);
        u_if.btn_start = 1'b1;
        @(negedge clk);
        u_if.btn_start = 1'b0;
        check_eq("game3_running", 32'(u_if.gamestate), 32'd1);
        wait_tick(20, n_iv);
        wait_tick(20, n_iv);
        check_eq("game3_score", 32'(u_if.score), 32'h0001);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_state", 32'(u_if.gamestate), 32'd0);
        check_eq("arst_score", 32'(u_if.score), 32'h0);
        check_eq("arst_hi",    32'(u_if.hi_score), 32'h0);
        check_eq("arst_speed", 32'(u_if.speed_lvl), 32'd0);
        check_eq("arst_tick",  32'(u_if.scroll_tick), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
